// File: rtl/spi_rx_if.sv
// SPI receive link plus the received-word valid/ready port, grouped as one bundle.
// The master modport is the side that drives the SPI pins and accepts words.
interface spi_rx_if #(
  parameter int DATA_W = 8
) ();
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  modport slave (
    input  sclk, cs, mosi, rx_ready,
    output rx_data, rx_valid, busy, overrun, frame_err
  );

  modport master (
    output sclk, cs, mosi, rx_ready,
    input  rx_data, rx_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/spi_rx_slave.sv
// SPI slave receiver: synchronises sclk/cs/mosi into clk and deserialises one word per cs-low frame.
// Define SPI_RX_FRAME_CHECK_EN to enable the frame_err pulse on short frames.
module spi_rx_slave #(
  parameter int DATA_W      = 8,
  parameter int LEAD_BITS   = 1,
  parameter int MSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_rx_if.slave    bus
);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int LEAD_W = (LEAD_BITS > 0) ? $clog2(LEAD_BITS + 1) : 1;
`ifdef SPI_RX_FRAME_CHECK_EN
  localparam logic FRAME_CHECK = 1'b1;
`else
  localparam logic FRAME_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_SHIFT, ST_HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic                   sclk_dly_r, cs_dly_r;
  state_t                 state_r, state_nxt_s;
  logic [LEAD_W-1:0]      skip_cnt_r, skip_nxt_s, skip_inc_s;
  logic [BIT_W-1:0]       bit_cnt_r, bit_nxt_s, bit_inc_s;
  logic [DATA_W-1:0]      shreg_r, shreg_nxt_s;
  logic                   seen_fall_r, seen_nxt_s;
  logic                   word_done_s, short_s;
  logic [DATA_W-1:0]      rx_data_r;
  logic                   rx_valid_r, busy_r, overrun_r, frame_err_r;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_fall_s, cs_fall_s, cs_rise_s;

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_fall_s = sclk_dly_r & ~sclk_s;
  assign cs_fall_s   = cs_dly_r & ~cs_s;
  assign cs_rise_s   = ~cs_dly_r & cs_s;
  assign skip_inc_s  = skip_cnt_r + LEAD_W'(1);
  assign bit_inc_s   = bit_cnt_r + BIT_W'(1);

  // Identical synchroniser chains keep sclk, cs and mosi aligned; plus edge-detect delay taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_dly_r  <= 1'b0;
      cs_dly_r    <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
      sclk_dly_r  <= sclk_s;
      cs_dly_r    <= cs_s;
    end
  end

  // Frame FSM next-state: lead-bit skipping, shifting, and cs-rise abort (cs rise beats sclk fall).
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    bit_nxt_s   = bit_cnt_r;
    shreg_nxt_s = shreg_r;
    seen_nxt_s  = seen_fall_r;
    word_done_s = 1'b0;
    short_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = (LEAD_BITS > 0) ? ST_SKIP : ST_SHIFT;
          skip_nxt_s  = {LEAD_W{1'b0}};
          bit_nxt_s   = {BIT_W{1'b0}};
          shreg_nxt_s = {DATA_W{1'b0}};
          seen_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
          short_s     = 1'b1;
        end else if (sclk_fall_s) begin
          seen_nxt_s = 1'b1;
          skip_nxt_s = skip_inc_s;
          if (skip_inc_s == LEAD_W'(LEAD_BITS)) begin
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_SKIP;
          end
        end else begin
          state_nxt_s = ST_SKIP;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
          short_s     = 1'b1;
        end else if (sclk_fall_s) begin
          seen_nxt_s = 1'b1;
          bit_nxt_s  = bit_inc_s;
          if (MSB_FIRST != 0) begin
            shreg_nxt_s = {shreg_r[DATA_W-2:0], mosi_s};
          end else begin
            shreg_nxt_s = {mosi_s, shreg_r[DATA_W-1:1]};
          end
          if (bit_inc_s == BIT_W'(DATA_W)) begin
            state_nxt_s = ST_HOLD;
            word_done_s = 1'b1;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and frame bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      skip_cnt_r  <= {LEAD_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      shreg_r     <= {DATA_W{1'b0}};
      seen_fall_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      skip_cnt_r  <= skip_nxt_s;
      bit_cnt_r   <= bit_nxt_s;
      shreg_r     <= shreg_nxt_s;
      seen_fall_r <= seen_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  // Output word holding register: load on free slot, drop and flag overrun when still full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= {DATA_W{1'b0}};
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overrun_r   <= 1'b0;
      frame_err_r <= short_s & seen_fall_r & FRAME_CHECK;
      if (word_done_s) begin
        if (!rx_valid_r || bus.rx_ready) begin
          rx_data_r  <= shreg_nxt_s;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r  <= 1'b1;
        end
      end else if (rx_valid_r && bus.rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_spi_rx_slave.sv
// Directed bench for spi_rx_slave: an LSB-first instance (dut0) and an MSB-first instance (dut1)
// share one SPI master driven from the initial block.
module tb_spi_rx_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_r = 1'b0;
  logic cs_r = 1'b1;
  logic mosi_r = 1'b0;
  logic ready0 = 1'b0;
  logic ready1 = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] acc_q[$];

  always #5 clk = ~clk;

  spi_rx_if #(.DATA_W(8)) bus0 ();
  spi_rx_if #(.DATA_W(8)) bus1 ();

  assign bus0.sclk = sclk_r;
  assign bus0.cs = cs_r;
  assign bus0.mosi = mosi_r;
  assign bus0.rx_ready = ready0;
  assign bus1.sclk = sclk_r;
  assign bus1.cs = cs_r;
  assign bus1.mosi = mosi_r;
  assign bus1.rx_ready = ready1;

  spi_rx_slave #(.DATA_W(8), .LEAD_BITS(1), .MSB_FIRST(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  spi_rx_slave #(.DATA_W(8), .LEAD_BITS(1), .MSB_FIRST(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Record accepted words and count overrun / frame_err pulse cycles on dut0.
  always @(posedge clk) begin
    if (bus0.rx_valid && bus0.rx_ready) acc_q.push_back(bus0.rx_data);
    if (bus0.overrun) ovr_cnt <= ovr_cnt + 1;
    if (bus0.frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SPI bit: mosi changes on sclk rise, slave samples on the fall.
  task automatic send_bit(input logic b);
    sclk_r = 1'b1;
    mosi_r = b;
    #20;
    sclk_r = 1'b0;
    #20;
  endtask

  task automatic begin_frame();
    @(negedge clk);
    cs_r = 1'b0;
    mosi_r = 1'b0;
    #40;
    send_bit(1'b0);
  endtask

  task automatic end_frame();
    send_bit(1'b0);
    #20;
    cs_r = 1'b1;
    #60;
  endtask

  task automatic send_word(input logic [7:0] d, input bit msb);
    begin_frame();
    for (int i = 0; i < 8; i++) send_bit(msb ? d[7-i] : d[i]);
    end_frame();
  endtask

  task automatic drain0();
    @(negedge clk);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
  endtask

  initial begin
    int base;
    int o0;
    int f0;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] ferr_exp;

    // Reset state
    #23;
    check_val("rst_data", bus0.rx_data, 32'h0);
    check_val("rst_valid", bus0.rx_valid, 32'h0);
    check_val("rst_busy", bus0.busy, 32'h0);
    check_val("rst_overrun", bus0.overrun, 32'h0);
    check_val("rst_frame_err", bus0.frame_err, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single word held with rx_ready low, then one-cycle accept
    send_word(8'hA5, 1'b0);
    check_val("t1_data", bus0.rx_data, 32'hA5);
    repeat (5) @(negedge clk);
    check_val("t1_valid_held", bus0.rx_valid, 32'h1);
    drain0();
    check_val("t1_valid_clr", bus0.rx_valid, 32'h0);

    // 2: back-to-back frames with rx_ready high
    base = acc_q.size();
    o0 = ovr_cnt;
    ready0 = 1'b1;
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    ready0 = 1'b0;
    check_val("t2_count", acc_q.size() - base, 32'd2);
    w0 = (acc_q.size() > base) ? {24'h0, acc_q[base]} : 32'hDEAD;
    w1 = (acc_q.size() > base + 1) ? {24'h0, acc_q[base+1]} : 32'hDEAD;
    check_val("t2_word0", w0, 32'h3C);
    check_val("t2_word1", w1, 32'hC3);
    check_val("t2_overrun", ovr_cnt - o0, 32'd0);
    check_val("t2_valid", bus0.rx_valid, 32'h0);

    // 3: second word lost while the first is unread
    o0 = ovr_cnt;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check_val("t3_data", bus0.rx_data, 32'h11);
    check_val("t3_valid", bus0.rx_valid, 32'h1);
    check_val("t3_overrun", ovr_cnt - o0, 32'd1);
    drain0();

    // 4: short frame after 4 data bits of 0xFF, then a good frame
    f0 = ferr_cnt;
    begin_frame();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check_val("t4_busy", bus0.busy, 32'h1);
    cs_r = 1'b1;
    #80;
`ifdef SPI_RX_FRAME_CHECK_EN
    ferr_exp = 32'd1;
`else
    ferr_exp = 32'd0;
`endif
    check_val("t4_valid", bus0.rx_valid, 32'h0);
    check_val("t4_frame_err", ferr_cnt - f0, ferr_exp);
    check_val("t4_busy_end", bus0.busy, 32'h0);
    send_word(8'h7E, 1'b0);
    check_val("t4_data", bus0.rx_data, 32'h7E);
    check_val("t4_valid2", bus0.rx_valid, 32'h1);
    drain0();

    // 5: asynchronous reset mid-frame, then a full frame
    begin_frame();
    for (int i = 0; i < 3; i++) send_bit(i == 0 ? 1'b1 : 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_data", bus0.rx_data, 32'h0);
    check_val("t5_rst_valid", bus0.rx_valid, 32'h0);
    check_val("t5_rst_busy", bus0.busy, 32'h0);
    cs_r = 1'b1;
    sclk_r = 1'b0;
    #40;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_word(8'h81, 1'b0);
    check_val("t5_data", bus0.rx_data, 32'h81);
    check_val("t5_valid", bus0.rx_valid, 32'h1);
    drain0();

    // 6: MSB-first instance; the LSB-first instance sees the bit-reversed value
    @(negedge clk);
    ready1 = 1'b0;
    send_word(8'h01, 1'b1);
    check_val("t6_msb_data", bus1.rx_data, 32'h01);
    check_val("t6_msb_valid", bus1.rx_valid, 32'h1);
    check_val("t6_lsb_data", bus0.rx_data, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
